// File: rtl/piezo_pkg.sv
`default_nettype none
// ============================================================================
// Module : piezo_pkg
// Brief  : Note codes, nominal periods and period classifier for the piezo
//          tune decoder.
// Rev    : 1.0  initial release
// ============================================================================
package piezo_pkg;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_A6   = 3'd1,
        NOTE_D7   = 3'd2,
        NOTE_E7   = 3'd3,
        NOTE_F7   = 3'd4,
        NOTE_UNK  = 3'd5
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam int unsigned PERIOD_W  = 16;
    localparam int unsigned TOL_SHIFT = 6;

    localparam logic [PERIOD_W-1:0] NOM_A6 = 16'd28409;
    localparam logic [PERIOD_W-1:0] NOM_D7 = 16'd21285;
    localparam logic [PERIOD_W-1:0] NOM_E7 = 16'd18961;
    localparam logic [PERIOD_W-1:0] NOM_F7 = 16'd17896;

    // Window is inclusive on both ends; one extra bit keeps nom+tol from wrapping.
    function automatic logic in_tol(input logic [PERIOD_W-1:0] p,
                                    input logic [PERIOD_W-1:0] nom);
        logic [PERIOD_W:0] lo;
        logic [PERIOD_W:0] hi;
        lo = {1'b0, nom} - {1'b0, (nom >> TOL_SHIFT)};
        hi = {1'b0, nom} + {1'b0, (nom >> TOL_SHIFT)};
        return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
    endfunction

    function automatic note_t classify(input logic [PERIOD_W-1:0] p);
        if (in_tol(p, NOM_A6))      return NOTE_A6;
        else if (in_tol(p, NOM_D7)) return NOTE_D7;
        else if (in_tol(p, NOM_E7)) return NOTE_E7;
        else if (in_tol(p, NOM_F7)) return NOTE_F7;
        else                        return NOTE_UNK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piezo_period_meas.sv
`default_nettype none
// ============================================================================
// Module : piezo_period_meas
// Brief  : Synchronises the differential piezo pins, detects rising edges,
//          measures the edge-to-edge period and flags non-complementary pins.
// Rev    : 1.0  initial release
// ============================================================================
module piezo_period_meas
    import piezo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                piezo,
    input  logic                piezo_n,
    output logic                rise_edge,
    output logic [PERIOD_W-1:0] period,
    output logic                err_compl
);

    logic [1:0]          p_sync_q, p_sync_d;
    logic [1:0]          n_sync_q, n_sync_d;
    logic                p_prev_q, p_prev_d;
    logic                edge_q, edge_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                eq_prev_q, eq_prev_d;
    logic                err_q, err_d;
    logic                pins_eq;

    always_comb begin
        p_sync_d  = {p_sync_q[0], piezo};
        n_sync_d  = {n_sync_q[0], piezo_n};
        p_prev_d  = p_sync_q[1];
        edge_d    = p_sync_q[1] & ~p_prev_q;
        pins_eq   = (p_sync_q[1] == n_sync_q[1]);
        eq_prev_d = pins_eq;
        // Two consecutive equal samples are required so one cycle of pin skew is tolerated.
        err_d     = err_q | (pins_eq & eq_prev_q);
        cnt_d     = cnt_q;
        // The edge cycle itself counts, so the value seen at the next edge is the full period.
        if (edge_q) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_sync_q  <= 2'b00;
            n_sync_q  <= 2'b11;
            p_prev_q  <= 1'b0;
            edge_q    <= 1'b0;
            cnt_q     <= '0;
            eq_prev_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_sync_q  <= p_sync_d;
            n_sync_q  <= n_sync_d;
            p_prev_q  <= p_prev_d;
            edge_q    <= edge_d;
            cnt_q     <= cnt_d;
            eq_prev_q <= eq_prev_d;
            err_q     <= err_d;
        end
    end

    assign rise_edge = edge_q;
    assign period    = cnt_q;
    assign err_compl = err_q;

endmodule
`default_nettype wire

// File: rtl/piezo_decoder.sv
`default_nettype none
// ============================================================================
// Module : piezo_decoder
// Brief  : Classifies piezo periods into notes and reports each completed
//          note with its duration in clock cycles.
// Rev    : 1.0  initial release
// ============================================================================
module piezo_decoder
    import piezo_pkg::*;
#(
    parameter int unsigned SILENCE_CLKS = 60000,
    parameter int unsigned DUR_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             piezo,
    input  logic             piezo_n,
    output logic             note_vld,
    output logic [2:0]       note,
    output logic [DUR_W-1:0] note_dur,
    output logic             active,
    output logic             err_compl
);

    logic                rise_edge;
    logic [PERIOD_W-1:0] period;
    logic                timeout;
    note_t               cls;

    state_t              state_q, state_d;
    note_t               cur_note_q, cur_note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                note_vld_q, note_vld_d;
    note_t               note_q, note_d;
    logic [DUR_W-1:0]    note_dur_q, note_dur_d;

    piezo_period_meas u_meas (
        .clk       (clk),
        .rst       (rst),
        .piezo     (piezo),
        .piezo_n   (piezo_n),
        .rise_edge (rise_edge),
        .period    (period),
        .err_compl (err_compl)
    );

    function automatic logic [DUR_W-1:0] sat_add(input logic [DUR_W-1:0]    a,
                                                 input logic [PERIOD_W-1:0] b);
        logic [DUR_W:0] s;
        s = {1'b0, a} + (DUR_W+1)'(b);
        return s[DUR_W] ? '1 : s[DUR_W-1:0];
    endfunction

    assign timeout = (32'(period) == SILENCE_CLKS);
    assign cls     = classify(period);

    // An edge always takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_d    = state_q;
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        note_vld_d = 1'b0;
        note_d     = note_q;
        note_dur_d = note_dur_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_edge) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise_edge) begin
                    cur_note_d = cls;
                    dur_d      = sat_add('0, period);
                    state_d    = ST_TRACK;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (rise_edge) begin
                    if (cls == cur_note_q) begin
                        dur_d = sat_add(dur_q, period);
                    end else begin
                        note_vld_d = 1'b1;
                        note_d     = cur_note_q;
                        note_dur_d = dur_q;
                        cur_note_d = cls;
                        dur_d      = sat_add('0, period);
                    end
                end else if (timeout) begin
                    note_vld_d = 1'b1;
                    note_d     = cur_note_q;
                    note_dur_d = dur_q;
                    cur_note_d = NOTE_NONE;
                    dur_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_note_q <= NOTE_NONE;
            dur_q      <= '0;
            note_vld_q <= 1'b0;
            note_q     <= NOTE_NONE;
            note_dur_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            dur_q      <= dur_d;
            note_vld_q <= note_vld_d;
            note_q     <= note_d;
            note_dur_q <= note_dur_d;
        end
    end

    assign note_vld = note_vld_q;
    assign note     = note_q;
    assign note_dur = note_dur_q;
    assign active   = (state_q == ST_TRACK);

endmodule
`default_nettype wire

// File: doc/piezo_decoder.md
# piezo_decoder

Receiver for the piezo tune output: measures the period of the differential piezo square wave, classifies each period as a note (A6/D7/E7/F7) and reports each completed note with its duration in clock cycles. It sits in test benches and self-check tops, attached to the `piezo`/`piezo_n` pins of the tune player, so tune content and timing are checked automatically rather than by ear or waveform.

## Interface
- `SILENCE_CLKS`, default 60000: cycles without a rising edge after which the current note is closed.
- `DUR_W`, default 24: width of the duration output.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `piezo`  in  1  piezo drive, asynchronous to `clk`.
- `piezo_n`  in  1  complementary drive; must equal `~piezo`.
- `note_vld`  out  1  one-cycle pulse: `note`/`note_dur` valid.
- `note`  out  3  `note_t` code of the completed note.
- `note_dur`  out  DUR_W  note duration in clocks, saturating at all-ones.
- `active`  out  1  high while a note is being tracked (TRACK state).
- `err_compl`  out  1  sticky: `piezo`/`piezo_n` not complementary.

## Operation
- `piezo` and `piezo_n` each pass through a 2-FF synchronizer. Rising-edge detect on synced `piezo`.
- 16-bit period counter: cleared on each rising edge, else increments, saturating at 65535.
- Classify each completed period P. A note matches if P is in [NOM-(NOM>>6), NOM+(NOM>>6)], inclusive.
  - A6: NOM = 28409.
  - D7: NOM = 21285.
  - E7: NOM = 18961.
  - F7: NOM = 17896.
  - Otherwise the class is NOTE_UNK.
- FSM states:
  - IDLE: a rising edge moves to ARM; record edge as `t_prev`.
  - ARM: next rising edge: `cur_note` = class(P), `dur` = P, note start = `t_prev`; go to TRACK. If the counter reaches SILENCE_CLKS, return to IDLE with no report.
  - TRACK, rising edge with class == `cur_note`: `dur += P`.
  - TRACK, rising edge with class != `cur_note`: report old note with `dur` excluding P. Then `cur_note` = class, `dur` = P (new note starts at the previous edge). Stay in TRACK.
  - TRACK, counter reaches SILENCE_CLKS: report `cur_note`/`dur` and go to IDLE. The trailing partial period is not counted.
- `dur` saturates at 2^DUR_W-1.
- `err_compl` sets when synced `piezo == piezo_n` for 2 consecutive cycles, which tolerates 1-cycle skew. It clears only on reset.

## Timing
- Reset values:
  - `note_vld` = 0, `note` = NOTE_NONE (0), `note_dur` = 0, `active` = 0, `err_compl` = 0.
  - FSM in IDLE; counters and `dur` cleared.
- Pin to internal edge takes 3 cycles: 2 sync flops plus edge detect.
- `note_vld` is registered. It asserts the cycle after the internal edge or the timeout count.
- `note` and `note_dur` hold their value until the next report.
- A note change and a duration saturation in the same cycle: report the saturated value.
- Reset mid-note discards the note: no `note_vld` is generated.
- A timeout and a rising edge in the same cycle: the edge wins and no timeout is taken.

## Structure
- `piezo_pkg` holds:
  - `note_t` enum: NONE = 0, A6, D7, E7, F7, UNK.
  - Nominal period constants.
  - Tolerance shift (6).
  - Period counter width (16).
- Sub-module `piezo_period_meas` contains the synchronizers, edge detect, saturating period counter and complement check. It outputs `edge`, `period[15:0]` and `err_compl`.
- The top module holds the classifier, FSM and duration accumulator.

## Test plan
- Reset: drive X-free idle inputs and assert `rst` -> all outputs 0, `note` = NONE, no `note_vld`.
- D7, 101 rising edges at period 21285, then `piezo` held low -> one `note_vld`, SILENCE_CLKS+1 cycles after the last internal edge, with `note` = D7 and `note_dur` = 2128500.
- D7 for 50 periods, then E7 (18961) for 40 periods, then silence -> pulse with D7/1064250, then pulse with E7/758440. `active` stays 1 between the two reports.
- Tolerance boundary: period 21617 -> D7; period 21618 -> UNK; period 20000 for 10 periods -> UNK with `note_dur` 200000.
- `piezo_n` forced equal to `piezo` for 1 cycle -> `err_compl` = 0. Forced equal for 3 cycles -> `err_compl` = 1, and it stays 1 after the inputs recover until `rst`.
- `rst` pulsed after 30 F7 periods -> outputs return to 0 asynchronously and no `note_vld`. A fresh tone afterwards is decoded normally.
